// File: rtl/fifo_destino_pkg.sv
// fifo_destino_pkg: word layout and default geometry shared by the router, destination FIFOs and bench.
package fifo_destino_pkg;
    localparam int DATA_W       = 6;
    localparam int ADDR_W       = 2;
    localparam int ALMOST_FULL  = 3;
    localparam int ALMOST_EMPTY = 1;
    typedef struct packed {
        logic [1:0] cls;
        logic [3:0] payload;
    } word_t;
endpackage

// File: rtl/memoria_fifo.sv
// memoria_fifo: DEPTH x DATA_WIDTH register file, synchronous write and synchronous read, no reset.
module memoria_fifo #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/fifo_destino.sv
// fifo_destino: per-destination FIFO with pause back-pressure, registered pop data and sticky overflow flag.
module fifo_destino
    import fifo_destino_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_W,
    parameter int ADDR_WIDTH   = ADDR_W,
    parameter int ALMOST_FULL  = fifo_destino_pkg::ALMOST_FULL,
    parameter int ALMOST_EMPTY = fifo_destino_pkg::ALMOST_EMPTY
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  pause,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  error
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, valid_d, error_q, error_d, loaded_q, loaded_d;
    logic                  wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] rd_data;
    always_comb begin
        rd_ok    = pop && !empty;
        wr_ok    = push && (!full || rd_ok);
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = (wr_ok && !rd_ok) ? cnt_q + 1'b1 :
                   (rd_ok && !wr_ok) ? cnt_q - 1'b1 : cnt_q;
        valid_d  = rd_ok;
        error_d  = error_q || (push && !wr_ok);
        loaded_d = loaded_q || rd_ok;
    end
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            loaded_q <= loaded_d;
        end
    end
    // The RAM read port has no reset, so data_out reads as zero until the first pop after reset.
    memoria_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk    (clk),
        .wr_en  (wr_ok && reset_L),
        .wr_addr(wr_ptr_q),
        .wr_data(data_in),
        .rd_en  (rd_ok && reset_L),
        .rd_addr(rd_ptr_q),
        .rd_data(rd_data)
    );
    assign data_out     = loaded_q ? rd_data : '0;
    assign valid        = valid_q;
    assign error        = error_q;
    assign full         = cnt_q == CNT_W'(DEPTH);
    assign empty        = cnt_q == '0;
    assign pause        = cnt_q >= CNT_W'(ALMOST_FULL);
    assign almost_empty = cnt_q <= CNT_W'(ALMOST_EMPTY);
endmodule

// File: doc/fifo_destino.md
# fifo_destino

Destination FIFO on the transmit path, directly downstream of the arbitration/routing stage. One instance per destination (D0, D1). Each instance accepts 6-bit words pushed by the router, buffers them, and returns an almost-full `pause` back to the router so that no word is lost. The next stage drains it with a pop/valid handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 6, word width; bits [5:4] carry class/destination, [3:0] payload.
- `ADDR_WIDTH`, 2, depth = 2^ADDR_WIDTH = 4 entries.
- `ALMOST_FULL`, 3, `pause` asserts when occupancy ≥ this value. Legal range 1..DEPTH-1.
- `ALMOST_EMPTY`, 1, `almost_empty` asserts when occupancy ≤ this value. Legal range 0..ALMOST_FULL-1.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset_L`, in, 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `push`, in, 1: write request from the router; this is D0_push/D1_push.
- `data_in`, in, DATA_WIDTH: word to write; this is D0_out/D1_out.
- `pop`, in, 1: read request from the downstream stage.
- `data_out`, out, DATA_WIDTH: read word, registered.
- `valid`, out, 1: `data_out` holds a newly popped word this cycle.
- `pause`, out, 1: almost-full indication back to the router.
- `full`, out, 1: occupancy == DEPTH.
- `empty`, out, 1: occupancy == 0.
- `almost_empty`, out, 1: occupancy ≤ ALMOST_EMPTY.
- `error`, out, 1: sticky overflow flag.

## Operation
- State:
  - write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_WIDTH bits; both wrap modulo DEPTH.
  - occupancy counter `cnt`, ADDR_WIDTH+1 bits, range 0..DEPTH.
- Reset (`reset_L`=0 at an edge):
  - pointers, `cnt`, `data_out`, `valid` and `error` are all cleared to 0.
  - resulting outputs: `empty`=1, `almost_empty`=1, `full`=0, `pause`=0.
  - memory contents are not cleared.
  - Reset mid-operation discards all stored words. Push or pop asserted in that cycle is ignored.
- Accepted write: `push`=1 and (`full`=0 or an accepted pop in the same cycle). Then `mem[wr_ptr]` ← `data_in` and `wr_ptr` increments.
- Accepted read: `pop`=1 and `empty`=0. Then `data_out` ← `mem[rd_ptr]`, `rd_ptr` increments, and `valid`=1 on the next cycle.
- `cnt` update: +1 for a write-only cycle, −1 for a read-only cycle, unchanged when both occur or neither occurs.
- Push while full with no pop:
  - the word is dropped; pointers and count are unchanged.
  - `error` goes to 1 and stays 1 until reset.
- Pop while empty:
  - ignored; `data_out` holds its previous value and `valid`=0.
  - no error is raised.
- Push and pop while empty: the write is performed, the pop is ignored (no fall-through); `cnt` becomes 1.
- Push and pop while full: both are performed; `cnt` stays DEPTH and `error` is not set.
- Flags are combinational decodes of the registered `cnt` only (no input-to-output path):
  - `full` = (`cnt`==DEPTH)
  - `empty` = (`cnt`==0)
  - `pause` = (`cnt`≥ALMOST_FULL)
  - `almost_empty` = (`cnt`≤ALMOST_EMPTY)

## Timing
- Write: `data_in` is captured at the edge where `push`=1. The flags reflect the new occupancy in the cycle after that edge.
- Read latency is 1 cycle: `pop` sampled at edge N gives `data_out`/`valid` valid after edge N, for one cycle. `valid` is a single-cycle pulse per accepted pop.
- Back-to-back pops on consecutive cycles deliver one word per cycle.
- `pause` is seen by the router one cycle after the occupancy reaches the threshold, so the router may issue one more push. ALMOST_FULL ≤ DEPTH-1 guarantees room for that word.
- `error` rises on the cycle after the offending push.

## Structure
- Shared constants header (included by the router, FIFOs and bench):
  - word width 6.
  - class field position [5:4].
  - default depth and thresholds.
- Sub-module `memoria_fifo`: DEPTH×DATA_WIDTH register file with synchronous write and synchronous read.
  - ports: `clk`, `wr_en`, `wr_addr`, `wr_data`, `rd_en`, `rd_addr`, `rd_data`.
  - no reset.
- `fifo_destino` holds the pointers, counter, flags and error logic.
- A synthesized twin, `fifo_destino_synth`, is produced for the behavioural-vs-synthesized comparison bench.

## Test plan
- Reset check: hold `reset_L`=0 for 2 cycles with `push`=1 and `data_in`=6'h2A.
  - Required: `empty`=1, `almost_empty`=1, `full`=0, `pause`=0, `valid`=0, `error`=0, `data_out`=0.
- Fill and pause: push 6'h01, 6'h12, 6'h23, 6'h34 on consecutive cycles.
  - `pause`=1 from the cycle after the third push; `full`=1 after the fourth; `error`=0.
- Overflow: while full, push 6'h3F with `pop`=0.
  - Word dropped, `error`=1 and held.
  - Subsequent pops return 01, 12, 23, 34 in order, each with a one-cycle `valid` pulse.
- Simultaneous push and pop:
  - When full: push 6'h05 with pop. `data_out`=oldest word, `cnt` stays 4, no error.
  - When empty: push 6'h07 with pop. `valid`=0, then `empty`=0.
- Wrap-around: 10 push/pop cycles with data 0..9 at occupancy 2.
  - Output sequence equals the input sequence delayed by 2 words; pointers wrap with no loss.
- Reset mid-operation: with 3 words stored, pulse `reset_L`=0 for 1 cycle.
  - `empty`=1 and `error`=0 afterwards.
  - The next push 6'h15 followed by a pop returns 6'h15.
  - Behavioural and synthesized outputs match on every cycle.
